// File: rtl/rf_mul_unit.sv
// Iterative shift-add multiplier fed by the register file read ports.
// Signed operands are reduced to magnitudes; the sign is restored at FIN.
module rf_mul_unit #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ProdLo,
    output logic [WIDTH-1:0] ProdHi,
    output logic             Overflow
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state;
    logic [2*WIDTH:0]   acc;
    logic [WIDTH-1:0]   mag_a;
    logic               neg;
    logic               sgn;
    logic [CW-1:0]      cnt;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a_in;
    logic [WIDTH-1:0]   mag_b_in;
    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] mag_p;
    logic [2*WIDTH-1:0] prod;
    logic               ovf;

    always_comb begin
        a_neg    = Signed & OpA[WIDTH-1];
        b_neg    = Signed & OpB[WIDTH-1];
        mag_a_in = a_neg ? -OpA : OpA;
        mag_b_in = b_neg ? -OpB : OpB;
        addend   = acc[0] ? {1'b0, mag_a} : '0;
        // acc[2*WIDTH] is always clear here, it only holds the carry briefly
        sum      = acc[2*WIDTH:WIDTH] + addend;
        mag_p    = acc[2*WIDTH-1:0];
        prod     = neg ? -mag_p : mag_p;
        if (sgn)
            ovf = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
        else
            ovf = prod[2*WIDTH-1:WIDTH] != '0;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            acc      <= '0;
            mag_a    <= '0;
            neg      <= 1'b0;
            sgn      <= 1'b0;
            cnt      <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            ProdLo   <= '0;
            ProdHi   <= '0;
            Overflow <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        mag_a <= mag_a_in;
                        neg   <= a_neg ^ b_neg;
                        sgn   <= Signed;
                        acc   <= {{(WIDTH+1){1'b0}}, mag_b_in};
                        cnt   <= CW'(WIDTH);
                        Busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= {1'b0, sum, acc[WIDTH-1:1]};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1))
                        state <= FIN;
                end
                FIN: begin
                    ProdHi   <= prod[2*WIDTH-1:WIDTH];
                    ProdLo   <= prod[WIDTH-1:0];
                    Overflow <= ovf;
                    Done     <= 1'b1;
                    Busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_mul_unit.sv
// Bench for rf_mul_unit: directed cases plus random ops
// checked against an integer-arithmetic reference.
module tb_rf_mul_unit;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic        sgn;
    logic [15:0] OpA;
    logic [15:0] OpB;
    logic        Busy;
    logic        Done;
    logic [15:0] ProdLo;
    logic [15:0] ProdHi;
    logic        Overflow;

    int errors = 0;
    int checks = 0;

    rf_mul_unit #(.WIDTH(16)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Start(Start),
        .Signed(sgn),
        .OpA(OpA),
        .OpB(OpB),
        .Busy(Busy),
        .Done(Done),
        .ProdLo(ProdLo),
        .ProdHi(ProdHi),
        .Overflow(Overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input logic s, output logic [15:0] hi,
                                  output logic [15:0] lo, output logic ov);
        longint pa;
        longint pb;
        longint p;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        p  = pa * pb;
        hi = p[31:16];
        lo = p[15:0];
        ov = s ? (hi != {16{lo[15]}}) : (hi != 16'h0);
    endfunction

    // Present a request for one edge; returns #1 after the sampling edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic s);
        @(negedge Clock);
        OpA   = a;
        OpB   = b;
        sgn   = s;
        Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        OpA   = $urandom;
        OpB   = $urandom;
        sgn   = $urandom;
    endtask

    // Cycles until Done is seen (0 means it never came).
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge Clock);
            #1;
            if (Done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        Start = 1'b0;
        sgn   = 1'b0;
        OpA   = '0;
        OpB   = '0;
        repeat (3) @(posedge Clock);
        #1;
        checks++;
        if ({Busy, Done, Overflow, ProdHi, ProdLo} !== 35'h0) begin
            errors++;
            $display("FAIL reset_state got=%h want=0",
                     {Busy, Done, Overflow, ProdHi, ProdLo});
        end
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic test_directed;
        logic [15:0] ta [7] = '{16'h00FF, 16'hFFFD, 16'h8000, 16'h8000,
                                16'hFFFF, 16'hFFFF, 16'h0000};
        logic [15:0] tb [7] = '{16'h0101, 16'h0005, 16'h8000, 16'h8000,
                                16'hFFFF, 16'hFFFF, 16'h1234};
        logic        ts [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] eh [7] = '{16'h0000, 16'hFFFF, 16'h4000, 16'h4000,
                                16'hFFFE, 16'h0000, 16'h0000};
        logic [15:0] el [7] = '{16'hFFFF, 16'hFFF1, 16'h0000, 16'h0000,
                                16'h0001, 16'h0001, 16'h0000};
        logic        eo [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        int n;
        for (int i = 0; i < 7; i++) begin
            start_op(ta[i], tb[i], ts[i]);
            checks++;
            if (Busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_after_start[%0d] got=%b want=1", i, Busy);
            end
            wait_done(n);
            checks++;
            if (n != 17) begin
                errors++;
                $display("FAIL latency[%0d] got=%0d want=17", i, n);
            end
            checks++;
            if ({ProdHi, ProdLo, Overflow, Busy} !==
                {eh[i], el[i], eo[i], 1'b0}) begin
                errors++;
                $display("FAIL directed[%0d] got=%h_%h ov=%b busy=%b want=%h_%h ov=%b busy=0",
                         i, ProdHi, ProdLo, Overflow, Busy, eh[i], el[i], eo[i]);
            end
        end
        @(posedge Clock);
        #1;
        checks++;
        if (Done !== 1'b0 || ProdLo !== el[6]) begin
            errors++;
            $display("FAIL done_pulse_width got done=%b lo=%h want done=0 lo=%h",
                     Done, ProdLo, el[6]);
        end
    endtask

    task automatic test_ignore_midrun;
        int n;
        int extra;
        start_op(16'h0011, 16'h0013, 1'b0);
        repeat (4) @(posedge Clock);
        start_op(16'h0002, 16'h0003, 1'b0);
        wait_done(n);
        checks++;
        if (n != 12) begin
            errors++;
            $display("FAIL midrun_latency got=%0d want=12", n);
        end
        checks++;
        if ({ProdHi, ProdLo, Overflow} !== {16'h0000, 16'h0143, 1'b0}) begin
            errors++;
            $display("FAIL midrun_result got=%h_%h ov=%b want=0000_0143 ov=0",
                     ProdHi, ProdLo, Overflow);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clock);
            #1;
            if (Done || Busy) extra++;
        end
        checks++;
        if (extra != 0 || ProdLo !== 16'h0143) begin
            errors++;
            $display("FAIL midrun_no_second_op got=%0d lo=%h want=0 lo=0143",
                     extra, ProdLo);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        start_op(16'h0100, 16'h0100, 1'b0);
        wait_done(n);
        checks++;
        if ({ProdHi, ProdLo, Overflow} !== {16'h0001, 16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL b2b_first got=%h_%h ov=%b want=0001_0000 ov=1",
                     ProdHi, ProdLo, Overflow);
        end
        start_op(16'h0002, 16'h0003, 1'b0);
        checks++;
        if ({Busy, ProdHi, ProdLo} !== {1'b1, 16'h0001, 16'h0000}) begin
            errors++;
            $display("FAIL b2b_hold got=%b_%h_%h want=1_0001_0000",
                     Busy, ProdHi, ProdLo);
        end
        wait_done(n);
        checks++;
        if (n != 17 || {ProdHi, ProdLo, Overflow} !== {16'h0000, 16'h0006, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second got n=%0d %h_%h ov=%b want n=17 0000_0006 ov=0",
                     n, ProdHi, ProdLo, Overflow);
        end
    endtask

    task automatic test_reset_midrun;
        int n;
        int seen;
        start_op(16'h1234, 16'h5678, 1'b0);
        repeat (5) @(posedge Clock);
        #1;
        Reset = 1'b0;
        #1;
        checks++;
        if ({Busy, Done, Overflow, ProdHi, ProdLo} !== 35'h0) begin
            errors++;
            $display("FAIL reset_midrun got=%h want=0",
                     {Busy, Done, Overflow, ProdHi, ProdLo});
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clock);
            #1;
            if (Done) seen++;
        end
        @(negedge Clock);
        Reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clock);
            #1;
            if (Done || Busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_no_done got=%0d want=0", seen);
        end
        start_op(16'h0007, 16'h0009, 1'b0);
        wait_done(n);
        checks++;
        if (n != 17 || {ProdHi, ProdLo, Overflow} !== {16'h0000, 16'h003F, 1'b0}) begin
            errors++;
            $display("FAIL after_reset got n=%0d %h_%h ov=%b want n=17 0000_003f ov=0",
                     n, ProdHi, ProdLo, Overflow);
        end
    endtask

    task automatic test_random;
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] hi;
        logic [15:0] lo;
        logic        ov;
        int n;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            s = $urandom_range(1, 0);
            if (i % 8 == 0) a = 16'h8000;
            if (i % 8 == 1) b = 16'hFFFF;
            model(a, b, s, hi, lo, ov);
            start_op(a, b, s);
            wait_done(n);
            checks++;
            if (n != 17 || {ProdHi, ProdLo, Overflow} !== {hi, lo, ov}) begin
                errors++;
                $display("FAIL random[%0d] a=%h b=%h s=%b got n=%0d %h_%h ov=%b want n=17 %h_%h ov=%b",
                         i, a, b, s, n, ProdHi, ProdLo, Overflow, hi, lo, ov);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_ignore_midrun;
        test_back_to_back;
        test_reset_midrun;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
